mux81_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 8:1 mux datapath among 8 requesters.
//  It drives the mux chip-select (CSn, active-low) and address (A[2:0]), and

---
 rtl/mux81_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_mux81_rr_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux81_rr_scheduler.sv
//------------------------------------------------------------------------------
// mux81_rr_scheduler : round-robin owner of a shared 8:1 mux (CSn/A/GNT)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux81_rr_scheduler #(
  parameter int HOLD_MAX   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic       CSn,
  output logic [2:0] A,
  output logic       BUSY
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      gnt_q, gnt_d;
  logic            csn_q, csn_d;
  logic [2:0]      a_q, a_d;
  logic            busy_q, busy_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic            arb_found;
  logic [2:0]      arb_win;
  logic [2:0]      arb_idx;

  // Search starts one past the last owner so a hogging channel goes to the back.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = 3'd0;
    arb_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      arb_idx = ptr_q + 3'(k);
      if (!arb_found && REQ[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    csn_d      = csn_q;
    a_d        = a_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d    = ST_GRANT;
          a_d        = arb_win;
          gnt_d      = 8'b1 << arb_win;
          csn_d      = 1'b0;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Request drop and hold expiry collapse into one release.
        if (!REQ[a_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d   = ST_GAP;
          csn_d     = 1'b1;
          gnt_d     = 8'h00;
          ptr_d     = a_q;
          gap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (arb_found) begin
            state_d    = ST_GRANT;
            a_d        = arb_win;
            gnt_d      = 8'b1 << arb_win;
            csn_d      = 1'b0;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
        csn_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 8'h00;
      csn_q      <= 1'b1;
      a_q        <= 3'd0;
      busy_q     <= 1'b0;
      ptr_q      <= 3'd7;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      csn_q      <= csn_d;
      a_q        <= a_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign GNT  = gnt_q;
  assign CSn  = csn_q;
  assign A    = a_q;
  assign BUSY = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux81_rr_scheduler.sv
//------------------------------------------------------------------------------
// tb_mux81_rr_scheduler : scenario tasks plus a cycle monitor against a model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux81_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt1, gnt3;
  logic       csn1, csn3;
  logic [2:0] a1, a3;
  logic       busy1, busy3;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mux81_rr_scheduler #(.HOLD_MAX(4), .GAP_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt1), .CSn(csn1), .A(a1), .BUSY(busy1)
  );

  mux81_rr_scheduler #(.HOLD_MAX(4), .GAP_CYCLES(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt3), .CSn(csn3), .A(a3), .BUSY(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Owner/run-length view of the scheduler: owner<0 means nobody holds the mux.
  typedef struct packed {
    int owner;
    int run;
    int gap_left;
    int ptr;
    int last_a;
    bit busy;
  } model_t;

  model_t m1, m3;

  function automatic model_t next_model(model_t m, logic [7:0] r, logic rs,
                                        int hmax, int gcyc);
    model_t n;
    bit     arb;
    bit     found;
    int     c;
    n     = m;
    arb   = 1'b0;
    found = 1'b0;
    if (rs) begin
      n.owner = -1; n.run = 0; n.gap_left = 0;
      n.ptr = 7; n.last_a = 0; n.busy = 1'b0;
      return n;
    end
    if (m.owner >= 0) begin
      if (!r[m.owner] || m.run >= hmax) begin
        n.ptr = m.owner; n.owner = -1; n.gap_left = gcyc; n.busy = 1'b1;
      end else begin
        n.run = m.run + 1;
      end
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
      if (n.gap_left == 0) begin
        arb = 1'b1;
        n.busy = 1'b0;
      end
    end else begin
      arb = 1'b1;
    end
    if (arb) begin
      for (int k = 1; k <= 8; k++) begin
        c = (n.ptr + k) % 8;
        if (!found && r[c]) begin
          found = 1'b1;
          n.owner = c; n.last_a = c; n.run = 1; n.busy = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= next_model(m1, req, rst, 4, 1);
    m3 <= next_model(m3, req, rst, 4, 3);
  end

  int low1 = 0;
  int low3 = 0;

  always @(negedge clk) begin
    logic [7:0] e1, e3;
    if (chk_en) begin
      e1 = (m1.owner >= 0) ? (8'h01 << m1.owner) : 8'h00;
      e3 = (m3.owner >= 0) ? (8'h01 << m3.owner) : 8'h00;
      n_cmp++;
      if (gnt1 !== e1 || csn1 !== (m1.owner < 0) || a1 !== 3'(m1.last_a) || busy1 !== m1.busy) begin
        n_fail++;
        $display("FAIL model_g1 t=%0t got gnt=%h csn=%b a=%0d busy=%b exp gnt=%h csn=%b a=%0d busy=%b",
                 $time, gnt1, csn1, a1, busy1, e1, (m1.owner < 0), m1.last_a, m1.busy);
      end
      n_cmp++;
      if (gnt3 !== e3 || csn3 !== (m3.owner < 0) || a3 !== 3'(m3.last_a) || busy3 !== m3.busy) begin
        n_fail++;
        $display("FAIL model_g3 t=%0t got gnt=%h csn=%b a=%0d busy=%b exp gnt=%h csn=%b a=%0d busy=%b",
                 $time, gnt3, csn3, a3, busy3, e3, (m3.owner < 0), m3.last_a, m3.busy);
      end
      n_cmp++;
      if (!$onehot0(gnt1) || ((gnt1 != 8'h00) !== (csn1 == 1'b0)) ||
          ((gnt1 != 8'h00) && !gnt1[a1])) begin
        n_fail++;
        $display("FAIL invariant_g1 t=%0t got gnt=%h csn=%b a=%0d exp onehot0 gnt matching csn and a",
                 $time, gnt1, csn1, a1);
      end
      n_cmp++;
      if (!$onehot0(gnt3) || ((gnt3 != 8'h00) !== (csn3 == 1'b0)) ||
          ((gnt3 != 8'h00) && !gnt3[a3])) begin
        n_fail++;
        $display("FAIL invariant_g3 t=%0t got gnt=%h csn=%b a=%0d exp onehot0 gnt matching csn and a",
                 $time, gnt3, csn3, a3);
      end
      low1 = (csn1 === 1'b0) ? low1 + 1 : 0;
      low3 = (csn3 === 1'b0) ? low3 + 1 : 0;
      n_cmp++;
      if (low1 > 4 || low3 > 4) begin
        n_fail++;
        $display("FAIL hold_limit t=%0t got low runs %0d/%0d exp <= 4", $time, low1, low3);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_en = 1'b1;
      n_cmp++;
      if (csn1 !== 1'b1 || gnt1 !== 8'h00 || a1 !== 3'd0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold got csn=%b gnt=%h a=%0d busy=%b exp csn=1 gnt=00 a=0 busy=0",
                 csn1, gnt1, a1, busy1);
      end
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (gnt1 !== 8'h01 || a1 !== 3'd0 || csn1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant got gnt=%h a=%0d csn=%b busy=%b exp gnt=01 a=0 csn=0 busy=1",
               gnt1, a1, csn1, busy1);
    end
  endtask

  task automatic test_single_short();
    do_reset();
    req = 8'h08;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (gnt1 !== 8'h08 || a1 !== 3'd3 || csn1 !== 1'b0) begin
        n_fail++;
        $display("FAIL short_grant cyc%0d got gnt=%h a=%0d csn=%b exp gnt=08 a=3 csn=0",
                 i, gnt1, a1, csn1);
      end
    end
    req = 8'h00;
    cyc();
    n_cmp++;
    if (csn1 !== 1'b1 || gnt1 !== 8'h00 || busy1 !== 1'b1 || a1 !== 3'd3) begin
      n_fail++;
      $display("FAIL short_gap got csn=%b gnt=%h busy=%b a=%0d exp csn=1 gnt=00 busy=1 a=3",
               csn1, gnt1, busy1, a1);
    end
    cyc();
    n_cmp++;
    if (busy1 !== 1'b0 || csn1 !== 1'b1 || a1 !== 3'd3) begin
      n_fail++;
      $display("FAIL short_idle got busy=%b csn=%b a=%0d exp busy=0 csn=1 a=3", busy1, csn1, a1);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    do_reset();
    req = 8'h81;
    for (int k = 0; k < 25; k++) begin
      cyc();
      case (k % 10)
        0, 1, 2, 3: exp_g = 8'h01;
        5, 6, 7, 8: exp_g = 8'h80;
        default:    exp_g = 8'h00;
      endcase
      n_cmp++;
      if (gnt1 !== exp_g) begin
        n_fail++;
        $display("FAIL round_robin k=%0d got gnt=%h exp %h", k, gnt1, exp_g);
      end
    end
  endtask

  task automatic test_sole_hog();
    logic [7:0] exp_g;
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 15; k++) begin
      cyc();
      exp_g = ((k % 5) == 4) ? 8'h00 : 8'h04;
      n_cmp++;
      if (gnt1 !== exp_g || csn1 !== (exp_g == 8'h00)) begin
        n_fail++;
        $display("FAIL sole_hog k=%0d got gnt=%h csn=%b exp gnt=%h", k, gnt1, csn1, exp_g);
      end
    end
  endtask

  task automatic test_mid_grant_reset();
    do_reset();
    req = 8'h20;
    cyc();
    cyc();
    n_cmp++;
    if (gnt1 !== 8'h20 || a1 !== 3'd5) begin
      n_fail++;
      $display("FAIL midrst_setup got gnt=%h a=%0d exp gnt=20 a=5", gnt1, a1);
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (csn1 !== 1'b1 || gnt1 !== 8'h00 || busy1 !== 1'b0 || a1 !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_clear got csn=%b gnt=%h busy=%b a=%0d exp csn=1 gnt=00 busy=0 a=0",
               csn1, gnt1, busy1, a1);
    end
    rst = 1'b0;
    req = 8'hFF;
    cyc();
    n_cmp++;
    if (gnt1 !== 8'h01 || a1 !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_regrant got gnt=%h a=%0d exp gnt=01 a=0", gnt1, a1);
    end
  endtask

  task automatic test_coincident_release();
    int g1, g3;
    bit d1, d3;
    logic [7:0] ng1, ng3;
    g1 = 0; g3 = 0; d1 = 1'b0; d3 = 1'b0; ng1 = 8'h00; ng3 = 8'h00;
    do_reset();
    req = 8'h01;
    for (int i = 0; i < 4; i++) cyc();
    // The next edge both drops REQ[0] and ends the 4-cycle hold.
    req = 8'h02;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!d1) begin
        if (csn1 === 1'b1) g1++;
        else begin d1 = 1'b1; ng1 = gnt1; end
      end
      if (!d3) begin
        if (csn3 === 1'b1) g3++;
        else begin d3 = 1'b1; ng3 = gnt3; end
      end
    end
    n_cmp++;
    if (!d1 || g1 != 1 || ng1 !== 8'h02) begin
      n_fail++;
      $display("FAIL coincident_g1 got gap=%0d next=%h done=%b exp gap=1 next=02 done=1", g1, ng1, d1);
    end
    n_cmp++;
    if (!d3 || g3 != 3 || ng3 !== 8'h02) begin
      n_fail++;
      $display("FAIL coincident_g3 got gap=%0d next=%h done=%b exp gap=3 next=02 done=1", g3, ng3, d3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: req = 8'h00;
          1: req = 8'h01 << $urandom_range(7, 0);
          default: req = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(79, 0) == 0);
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_short();
    test_round_robin();
    test_sole_hog();
    test_mid_grant_reset();
    test_coincident_release();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
